// File: rtl/tone_nco_if.sv
// Sequencer-to-NCO bundle: pitch request in, speaker/status out.
interface tone_nco_if;
    localparam int unsigned SOUND_W = 16;
    localparam int unsigned VOL_W   = 3;

    logic               enable;
    logic [SOUND_W-1:0] sound;
    logic [VOL_W-1:0]   volume;
    logic               speaker;
    logic               active;
    logic               wrap_pulse;
    logic [SOUND_W-1:0] freq_q;

    modport master (
        output enable, sound, volume,
        input  speaker, active, wrap_pulse, freq_q
    );

    modport slave (
        input  enable, sound, volume,
        output speaker, active, wrap_pulse, freq_q
    );
endinterface

// File: rtl/tone_nco.sv
// Phase-accumulator tone generator that retunes only at phase wrap.
// Optional PWM volume control is enabled by defining TONE_NCO_VOLUME_EN.
module tone_nco #(
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned SILENCE_MAX = 1
) (
    input  logic        sound_clock,
    input  logic        reset,
    tone_nco_if.slave   bus
);
    localparam int unsigned SUM_W   = ACC_W + 1;
    localparam int unsigned SOUND_W = 16;

    typedef enum logic {MUTE, RUN} state_t;

    state_t             state;
    logic [ACC_W-1:0]   phase;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   phase_next;
    logic               carry;
    logic               silence;
    logic               tone_on;

    assign sum        = {1'b0, phase} + SUM_W'(bus.freq_q);
    assign carry      = sum[ACC_W];
    assign phase_next = sum[ACC_W-1:0];
    assign silence    = (bus.sound <= SOUND_W'(SILENCE_MAX));
    assign tone_on    = (state == RUN) && phase[ACC_W-1];

    // Mode control and accumulation; frequency only changes on a wrap edge.
    always_ff @(posedge sound_clock) begin
        if (reset) begin
            state          <= MUTE;
            phase          <= '0;
            bus.freq_q     <= '0;
            bus.active     <= 1'b0;
            bus.wrap_pulse <= 1'b0;
        end else begin
            case (state)
                MUTE: begin
                    phase          <= '0;
                    bus.wrap_pulse <= 1'b0;
                    if (bus.enable && !silence) begin
                        bus.freq_q <= bus.sound;
                        state      <= RUN;
                        bus.active <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        state          <= MUTE;
                        phase          <= '0;
                        bus.active     <= 1'b0;
                        bus.wrap_pulse <= 1'b0;
                    end else if (carry) begin
                        bus.wrap_pulse <= 1'b1;
                        if (silence) begin
                            // Wrap lands in the low half, so stopping here is click-free.
                            state      <= MUTE;
                            phase      <= '0;
                            bus.active <= 1'b0;
                        end else begin
                            phase <= phase_next;
                            if (bus.sound != bus.freq_q) begin
                                bus.freq_q <= bus.sound;
                            end
                        end
                    end else begin
                        phase          <= phase_next;
                        bus.wrap_pulse <= 1'b0;
                    end
                end
                default: begin
                    state <= MUTE;
                    phase <= '0;
                end
            endcase
        end
    end

`ifdef TONE_NCO_VOLUME_EN
    logic [2:0] pwm_cnt;
    logic       vol_gate;

    always_ff @(posedge sound_clock) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
        end
    end

    // Full scale bypasses the PWM so volume 7 gives a solid high half-period.
    assign vol_gate    = (bus.volume == 3'd7) || (pwm_cnt < bus.volume);
    assign bus.speaker = tone_on && vol_gate;
`else
    logic unused_volume;

    assign unused_volume = ^bus.volume;
    assign bus.speaker   = tone_on;
`endif

endmodule

// File: tb/tb_tone_nco.sv
// Directed checks of tone_nco with a 12-bit accumulator.
module tb_tone_nco;
    localparam int unsigned ACC_W = 12;

    logic sound_clock = 1'b0;
    logic reset       = 1'b1;
    int   errors      = 0;
    int   checks      = 0;

    tone_nco_if bus ();

    tone_nco #(.ACC_W(ACC_W), .SILENCE_MAX(1)) dut (
        .sound_clock (sound_clock),
        .reset       (reset),
        .bus         (bus)
    );

    always #5 sound_clock = ~sound_clock;

    task automatic tick;
        @(posedge sound_clock);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.sound  = 16'd1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.sound  = 16'd565;
        bus.volume = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.speaker, bus.active, bus.freq_q} !== {1'b0, 1'b0, 16'd0}) begin
                errors++;
                $display("FAIL reset_hold[%0d]: speaker=%0b active=%0b freq_q=%0d, expected 0 0 0",
                         i, bus.speaker, bus.active, bus.freq_q);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.active, bus.freq_q} !== {1'b1, 16'd565}) begin
            errors++;
            $display("FAIL reset_release: active=%0b freq_q=%0d, expected 1 565", bus.active, bus.freq_q);
        end
    endtask

    task automatic test_run;
        logic [ACC_W-1:0] exp_ph;
        logic             exp_spk, exp_wrap;
        do_reset();
        bus.sound  = 16'd1024;
        bus.enable = 1'b1;
        tick();
        checks++;
        if ({bus.active, bus.freq_q, dut.phase, bus.speaker} !== {1'b1, 16'd1024, 12'd0, 1'b0}) begin
            errors++;
            $display("FAIL run_entry: active=%0b freq_q=%0d phase=%0d speaker=%0b, expected 1 1024 0 0",
                     bus.active, bus.freq_q, dut.phase, bus.speaker);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_ph   = 12'(((i % 4) + 1) * 1024);
            exp_spk  = (exp_ph >= 12'd2048);
            exp_wrap = ((i % 4) == 3);
            checks++;
            if ({dut.phase, bus.speaker, bus.wrap_pulse} !== {exp_ph, exp_spk, exp_wrap}) begin
                errors++;
                $display("FAIL run_seq[%0d]: phase=%0d speaker=%0b wrap=%0b, expected %0d %0b %0b",
                         i, dut.phase, bus.speaker, bus.wrap_pulse, exp_ph, exp_spk, exp_wrap);
            end
        end
    endtask

    task automatic test_retune;
        logic [ACC_W-1:0] exp_ph;
        tick();
        bus.sound = 16'd512;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_ph = 12'((i + 2) * 1024);
            checks++;
            if ({dut.phase, bus.freq_q, bus.wrap_pulse} !== {exp_ph, 16'd1024, 1'b0}) begin
                errors++;
                $display("FAIL retune_hold[%0d]: phase=%0d freq_q=%0d wrap=%0b, expected %0d 1024 0",
                         i, dut.phase, bus.freq_q, bus.wrap_pulse, exp_ph);
            end
        end
        tick();
        checks++;
        if ({dut.phase, bus.freq_q, bus.wrap_pulse} !== {12'd0, 16'd512, 1'b1}) begin
            errors++;
            $display("FAIL retune_wrap: phase=%0d freq_q=%0d wrap=%0b, expected 0 512 1",
                     dut.phase, bus.freq_q, bus.wrap_pulse);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_ph = 12'(k * 512);
            checks++;
            if ({dut.phase, bus.speaker, bus.wrap_pulse} !== {exp_ph, (k >= 4 && k <= 7), (k == 8)}) begin
                errors++;
                $display("FAIL retune_period[%0d]: phase=%0d speaker=%0b wrap=%0b, expected %0d %0b %0b",
                         k, dut.phase, bus.speaker, bus.wrap_pulse, exp_ph, (k >= 4 && k <= 7), (k == 8));
            end
        end
    endtask

    task automatic test_graceful_stop;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({dut.phase, bus.speaker} !== {12'd2048, 1'b1}) begin
            errors++;
            $display("FAIL grace_setup: phase=%0d speaker=%0b, expected 2048 1", dut.phase, bus.speaker);
        end
        bus.sound = 16'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.speaker, bus.active, bus.wrap_pulse} !== 3'b110) begin
                errors++;
                $display("FAIL grace_drain[%0d]: speaker=%0b active=%0b wrap=%0b, expected 1 1 0",
                         i, bus.speaker, bus.active, bus.wrap_pulse);
            end
        end
        tick();
        checks++;
        if ({bus.speaker, bus.active, bus.wrap_pulse, dut.phase} !== {3'b001, 12'd0}) begin
            errors++;
            $display("FAIL grace_wrap: speaker=%0b active=%0b wrap=%0b phase=%0d, expected 0 0 1 0",
                     bus.speaker, bus.active, bus.wrap_pulse, dut.phase);
        end
        tick();
        checks++;
        if ({bus.speaker, bus.active, bus.wrap_pulse, dut.phase} !== {3'b000, 12'd0}) begin
            errors++;
            $display("FAIL grace_after: speaker=%0b active=%0b wrap=%0b phase=%0d, expected 0 0 0 0",
                     bus.speaker, bus.active, bus.wrap_pulse, dut.phase);
        end
        // Silence code at the threshold keeps the NCO muted; one above starts it.
        tick();
        checks++;
        if (bus.active !== 1'b0) begin
            errors++;
            $display("FAIL silence_hold: active=%0b, expected 0", bus.active);
        end
        bus.sound = 16'd2;
        tick();
        checks++;
        if ({bus.active, bus.freq_q} !== {1'b1, 16'd2}) begin
            errors++;
            $display("FAIL silence_exit: active=%0b freq_q=%0d, expected 1 2", bus.active, bus.freq_q);
        end
    endtask

    task automatic test_hard_stop;
        do_reset();
        bus.sound  = 16'd1024;
        bus.enable = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.speaker !== 1'b1) begin
            errors++;
            $display("FAIL hard_setup: speaker=%0b, expected 1", bus.speaker);
        end
        bus.enable = 1'b0;
        tick();
        checks++;
        if ({bus.speaker, bus.active, bus.wrap_pulse, dut.phase} !== {3'b000, 12'd0}) begin
            errors++;
            $display("FAIL hard_stop: speaker=%0b active=%0b wrap=%0b phase=%0d, expected 0 0 0 0",
                     bus.speaker, bus.active, bus.wrap_pulse, dut.phase);
        end
        bus.sound  = 16'd847;
        bus.enable = 1'b1;
        tick();
        checks++;
        if ({bus.active, bus.freq_q} !== {1'b1, 16'd847}) begin
            errors++;
            $display("FAIL hard_reenable: active=%0b freq_q=%0d, expected 1 847", bus.active, bus.freq_q);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (dut.phase !== 12'd3388) begin
            errors++;
            $display("FAIL hard_accum: phase=%0d, expected 3388", dut.phase);
        end
        // Next edge would carry; disabling must suppress the wrap pulse.
        bus.enable = 1'b0;
        tick();
        checks++;
        if ({bus.wrap_pulse, bus.active, dut.phase} !== {2'b00, 12'd0}) begin
            errors++;
            $display("FAIL hard_vs_carry: wrap=%0b active=%0b phase=%0d, expected 0 0 0",
                     bus.wrap_pulse, bus.active, dut.phase);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        bus.sound  = 16'd1024;
        bus.enable = 1'b1;
        tick();
        tick();
        bus.sound = 16'd1;
        tick();
        checks++;
        if ({bus.active, dut.phase} !== {1'b1, 12'd2048}) begin
            errors++;
            $display("FAIL b2b_mid: active=%0b phase=%0d, expected 1 2048", bus.active, dut.phase);
        end
        bus.sound = 16'd700;
        tick();
        tick();
        checks++;
        if ({bus.wrap_pulse, bus.active, bus.freq_q, dut.phase} !== {2'b11, 16'd700, 12'd0}) begin
            errors++;
            $display("FAIL b2b_wrap: wrap=%0b active=%0b freq_q=%0d phase=%0d, expected 1 1 700 0",
                     bus.wrap_pulse, bus.active, bus.freq_q, dut.phase);
        end
        tick();
        checks++;
        if (dut.phase !== 12'd700) begin
            errors++;
            $display("FAIL b2b_newfreq: phase=%0d, expected 700", dut.phase);
        end
    endtask

`ifdef TONE_NCO_VOLUME_EN
    task automatic test_volume;
        int highs;
        do_reset();
        bus.sound  = 16'd2;
        bus.enable = 1'b1;
        bus.volume = 3'd2;
        for (int i = 0; i < 3000 && !dut.phase[ACC_W-1]; i++) tick();
        checks++;
        if (dut.phase[ACC_W-1] !== 1'b1) begin
            errors++;
            $display("FAIL vol_wait: phase_msb=%0b, expected 1 within budget", dut.phase[ACC_W-1]);
        end
        highs = 0;
        for (int i = 0; i < 8; i++) begin tick(); highs += int'(bus.speaker); end
        checks++;
        if (highs !== 2) begin
            errors++;
            $display("FAIL vol_2: highs=%0d, expected 2", highs);
        end
        bus.volume = 3'd7;
        highs = 0;
        for (int i = 0; i < 8; i++) begin tick(); highs += int'(bus.speaker); end
        checks++;
        if (highs !== 8) begin
            errors++;
            $display("FAIL vol_7: highs=%0d, expected 8", highs);
        end
        bus.volume = 3'd0;
        highs = 0;
        for (int i = 0; i < 8; i++) begin tick(); highs += int'(bus.speaker); end
        checks++;
        if ({highs, bus.active} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL vol_0: highs=%0d active=%0b, expected 0 1", highs, bus.active);
        end
    endtask
`endif

    initial begin
        bus.enable = 1'b0;
        bus.sound  = 16'd0;
        bus.volume = 3'd7;
        test_reset();
        test_run();
        test_retune();
        test_graceful_stop();
        test_hard_stop();
        test_back_to_back();
`ifdef TONE_NCO_VOLUME_EN
        test_volume();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
